branch_resolve_ctrl: RTL and testbench

//  ID-stage branch/jump controller. Sequences the comparison_unit: maps funct3 to its
//  sel code, waits for operands, decides taken/not-taken and computes the target.

---
 rtl/id_pkg.sv | 53 +++++
 rtl/comparison_unit.sv | 27 ++
 rtl/branch_resolve_ctrl.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared ID-stage definitions: funct3 codes, comparator selects, branch FSM states
// and the funct3 -> (sel, inv, legal) decode used by the branch controller.
package id_pkg;

  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LTU = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GTU = 3'd4,
    CMP_GT  = 3'd5
  } cmp_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } br_state_e;

  typedef struct packed {
    logic     legal;
    logic     inv;
    cmp_sel_e sel;
  } br_dec_t;

  // GE forms reuse the LT comparators with the result inverted.
  function automatic br_dec_t decode_funct3(input logic [F3_W-1:0] f3);
    br_dec_t d;
    d.legal = 1'b1;
    d.inv   = 1'b0;
    d.sel   = CMP_EQ;
    case (f3)
      F3_BEQ:  d.sel = CMP_EQ;
      F3_BNE:  d.sel = CMP_NE;
      F3_BLT:  d.sel = CMP_LT;
      F3_BGE:  begin d.sel = CMP_LT;  d.inv = 1'b1; end
      F3_BLTU: d.sel = CMP_LTU;
      F3_BGEU: begin d.sel = CMP_LTU; d.inv = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/comparison_unit.sv
// Operand comparator for branch resolution.
// Ports: a, b - operands; sel - comparison select; flag - comparison result.
module comparison_unit
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  cmp_sel_e        sel,
  output logic            flag
);

  always_comb begin
    flag = 1'b0;
    case (sel)
      CMP_EQ:  flag = (a == b);
      CMP_NE:  flag = (a != b);
      CMP_LTU: flag = (a < b);
      CMP_LT:  flag = ($signed(a) < $signed(b));
      CMP_GTU: flag = (a > b);
      CMP_GT:  flag = ($signed(a) > $signed(b));
      default: flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/jump controller: resolves conditional branches and jumps,
// issues a held redirect to IF with valid/ready, stalls ID while waiting,
// and keeps saturating branch statistics.
// Ports: clk/rst_n; br_* instruction info; pc/imm/rs1_data/rs2_data datapath;
//   opnd_ready, kill, redirect_ready control in; redirect_valid/redirect_pc,
//   flush_if, stall_id, br_done, illegal_br, misalign_err, br_cnt, taken_cnt out.
module branch_resolve_ctrl
  import id_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_is_jal,
  input  logic             br_is_jalr,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             opnd_ready,
  input  logic             kill,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             stall_id,
  output logic             br_done,
  output logic             illegal_br,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  br_state_e        state_q, state_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             br_done_q, br_done_d;
  logic             illegal_q, illegal_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  br_dec_t         dec_c;
  logic            cmp_flag;
  logic            is_cond_c;
  logic            resolve_c;
  logic            cond_taken_c;
  logic            taken_raw_c;
  logic            taken_c;
  logic            misalign_c;
  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] target_c;

  assign dec_c = decode_funct3(br_funct3);

  comparison_unit #(.XLEN(XLEN)) u_cmp (
    .a    (rs1_data),
    .b    (rs2_data),
    .sel  (dec_c.sel),
    .flag (cmp_flag)
  );

  // Decision and target for the instruction currently in ID.
  always_comb begin
    is_cond_c    = ~br_is_jal & ~br_is_jalr;
    resolve_c    = ((state_q == IDLE) || (state_q == WAIT)) & br_valid & opnd_ready & ~kill;
    cond_taken_c = is_cond_c & dec_c.legal & (cmp_flag ^ dec_c.inv);
    taken_raw_c  = br_is_jal | br_is_jalr | cond_taken_c;
    sum_c        = (br_is_jalr ? rs1_data : pc) + imm;
    target_c     = br_is_jalr ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
    misalign_c   = CHECK_ALIGN & taken_raw_c & target_c[1];
    taken_c      = taken_raw_c & ~misalign_c;
  end

  // Next-state, pulses and statistics.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    br_done_d     = 1'b0;
    illegal_d     = 1'b0;
    misalign_d    = 1'b0;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    case (state_q)
      IDLE, WAIT: begin
        if (resolve_c) begin
          state_d = taken_c ? REDIRECT : IDLE;
        end else if (br_valid & ~opnd_ready) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;

    if (resolve_c) begin
      redirect_pc_d = target_c;
      br_done_d     = 1'b1;
      illegal_d     = is_cond_c & ~dec_c.legal;
      misalign_d    = misalign_c;
      if (is_cond_c) begin
        if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (taken_c && (taken_cnt_q != CNT_MAX)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end

    redirect_valid_d = (state_d == REDIRECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_done_q        <= 1'b0;
      illegal_q        <= 1'b0;
      misalign_q       <= 1'b0;
      br_cnt_q         <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_done_q        <= br_done_d;
      illegal_q        <= illegal_d;
      misalign_q       <= misalign_d;
      br_cnt_q         <= br_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  // Stall while waiting on operands or while a redirect is outstanding; the
  // resolve cycle itself releases ID so the branch is consumed exactly once.
  assign stall_id = (state_q == REDIRECT) | (br_valid & ~opnd_ready);
  assign flush_if = redirect_valid_q & redirect_ready & ~kill;

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_done        = br_done_q;
  assign illegal_br     = illegal_q;
  assign misalign_err   = misalign_q;
  assign br_cnt         = br_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SAT   = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_valid, br_is_jal, br_is_jalr;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  pc, imm, rs1_data, rs2_data;
  logic             opnd_ready, kill, redirect_ready;
  logic             redirect_valid, flush_if, stall_id, br_done, illegal_br, misalign_err;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned      exp_br = 0;
  int unsigned      exp_tk = 0;
  logic [XLEN-1:0]  exp_pc = '0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .CHECK_ALIGN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_is_jal      (br_is_jal),
    .br_is_jalr     (br_is_jalr),
    .br_funct3      (br_funct3),
    .pc             (pc),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .opnd_ready     (opnd_ready),
    .kill           (kill),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .stall_id       (stall_id),
    .br_done        (br_done),
    .illegal_br     (illegal_br),
    .misalign_err   (misalign_err),
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural meaning of each branch form.
  function automatic void ref_br(input bit jal, input bit jalr, input bit [2:0] f3,
                                 input bit [31:0] pc_i, input bit [31:0] imm_i,
                                 input bit [31:0] a, input bit [31:0] b,
                                 output bit tk, output bit [31:0] tgt,
                                 output bit ill, output bit mis);
    bit c;
    c   = 1'b0;
    ill = 1'b0;
    tgt = pc_i + imm_i;
    if (jal) begin
      c = 1'b1;
    end else if (jalr) begin
      tgt = (a + imm_i) & 32'hFFFF_FFFE;
      c   = 1'b1;
    end else begin
      case (f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = ($signed(a) <  $signed(b));
        3'd5: c = ($signed(a) >= $signed(b));
        3'd6: c = (a <  b);
        3'd7: c = (a >= b);
        default: ill = 1'b1;
      endcase
    end
    mis = c && tgt[1];
    tk  = c && !mis;
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, "_br_cnt"},    32'(br_cnt),    32'(exp_br));
    check_eq({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(exp_tk));
  endtask

  // One branch through ID: n_wait cycles without operands, then resolve;
  // if taken, IF stalls redirect acceptance for n_rdy cycles, optionally killed.
  task automatic do_branch(input bit jal, input bit jalr, input bit [2:0] f3,
                           input bit [31:0] pc_i, input bit [31:0] imm_i,
                           input bit [31:0] a, input bit [31:0] b,
                           input int n_wait, input int n_rdy, input bit kill_red);
    bit tk, ill, mis;
    bit [31:0] tgt;
    br_valid = 1'b1; br_is_jal = jal; br_is_jalr = jalr; br_funct3 = f3;
    pc = pc_i; imm = imm_i; rs1_data = a; rs2_data = b;
    kill = 1'b0; redirect_ready = 1'b0;
    for (int i = 0; i < n_wait; i++) begin
      opnd_ready = 1'b0;
      #1 check_eq("wait_stall", 32'(stall_id), 32'd1);
      tick();
      check_eq("wait_no_done", 32'(br_done), 32'd0);
      check_eq("wait_no_redirect", 32'(redirect_valid), 32'd0);
    end
    opnd_ready = 1'b1;
    #1 check_eq("resolve_stall", 32'(stall_id), 32'd0);
    tick();
    ref_br(jal, jalr, f3, pc_i, imm_i, a, b, tk, tgt, ill, mis);
    exp_pc = tgt;
    if (!jal && !jalr) begin
      if (exp_br < SAT) exp_br++;
      if (tk && exp_tk < SAT) exp_tk++;
    end
    br_valid = 1'b0; opnd_ready = 1'b0;
    check_eq("br_done", 32'(br_done), 32'd1);
    check_eq("illegal_br", 32'(illegal_br), 32'(ill));
    check_eq("misalign_err", 32'(misalign_err), 32'(mis));
    check_eq("redirect_pc", redirect_pc, exp_pc);
    check_eq("redirect_valid", 32'(redirect_valid), 32'(tk));
    check_counters("resolve");
    if (tk) begin
      for (int d = 0; d < n_rdy; d++) begin
        #1 check_eq("hold_flush", 32'(flush_if), 32'd0);
        check_eq("hold_stall", 32'(stall_id), 32'd1);
        tick();
        check_eq("hold_valid", 32'(redirect_valid), 32'd1);
        check_eq("hold_pc", redirect_pc, exp_pc);
        check_eq("hold_no_done", 32'(br_done), 32'd0);
      end
      redirect_ready = 1'b1;
      kill = kill_red;
      #1 check_eq("accept_flush", 32'(flush_if), 32'(!kill_red));
      tick();
      redirect_ready = 1'b0;
      kill = 1'b0;
      check_eq("post_valid", 32'(redirect_valid), 32'd0);
      check_eq("post_stall", 32'(stall_id), 32'd0);
      check_counters("post");
    end else begin
      tick();
    end
    check_eq("done_pulse", 32'(br_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    br_valid = 1'b0; br_is_jal = 1'b0; br_is_jalr = 1'b0; br_funct3 = 3'd0;
    pc = '0; imm = '0; rs1_data = '0; rs2_data = '0;
    opnd_ready = 1'b0; kill = 1'b0; redirect_ready = 1'b0;
    tick(); tick();
    check_eq("rst_valid", 32'(redirect_valid), 32'd0);
    check_eq("rst_pc", redirect_pc, 32'd0);
    check_eq("rst_done", 32'(br_done), 32'd0);
    check_eq("rst_stall", 32'(stall_id), 32'd0);
    check_counters("rst");
    rst_n = 1'b1;
    tick();

    // BEQ taken, IF ready immediately.
    do_branch(0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, 0, 0);
    // BGE signed -1 >= 1 is false; BGEU is true.
    do_branch(0, 0, 3'b101, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    do_branch(0, 0, 3'b111, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    // BNE waits 3 cycles for operands, IF holds off 2 cycles.
    do_branch(0, 0, 3'b001, 32'h300, 32'h10, 32'd1, 32'd2, 3, 2, 0);
    // JALR to a misaligned target.
    do_branch(0, 1, 3'b000, 32'h400, 32'h0, 32'h1003, 32'd0, 0, 0, 0);
    // Illegal funct3.
    do_branch(0, 0, 3'b010, 32'h500, 32'h8, 32'd3, 32'd3, 0, 0, 0);
    // Taken branch killed while its redirect is pending.
    do_branch(1, 0, 3'b000, 32'h600, 32'h100, 32'd0, 32'd0, 1, 1, 1);

    // Kill coincident with resolve suppresses it entirely.
    br_valid = 1'b1; br_is_jal = 1'b0; br_is_jalr = 1'b0; br_funct3 = 3'b000;
    pc = 32'h700; imm = 32'h44; rs1_data = 32'd9; rs2_data = 32'd9;
    opnd_ready = 1'b1; kill = 1'b1;
    tick();
    kill = 1'b0; br_valid = 1'b0; opnd_ready = 1'b0;
    check_eq("kill_res_done", 32'(br_done), 32'd0);
    check_eq("kill_res_valid", 32'(redirect_valid), 32'd0);
    check_eq("kill_res_pc", redirect_pc, exp_pc);
    check_counters("kill_res");
    tick();

    // Randomized mix; CNT_W=4 makes the counters saturate along the way.
    for (int t = 0; t < 200; t++) begin
      int unsigned kind;
      bit [31:0] a, b, p, im;
      kind = $urandom_range(0, 9);
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      p  = $urandom & 32'hFFFF_FFFC;
      im = $urandom;
      do_branch(kind == 0, kind == 1, 3'($urandom_range(0, 7)), p, im, a, b,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 9) == 0);
    end
    check_eq("br_cnt_saturated", 32'(br_cnt), 32'(SAT));

    // Asynchronous reset in the middle of WAIT.
    br_valid = 1'b1; br_is_jal = 1'b0; br_is_jalr = 1'b0; br_funct3 = 3'b001;
    opnd_ready = 1'b0;
    tick();
    check_eq("pre_rst_stall", 32'(stall_id), 32'd1);
    #2;
    rst_n = 1'b0; br_valid = 1'b0;
    #1;
    exp_br = 0; exp_tk = 0; exp_pc = '0;
    check_eq("arst_valid", 32'(redirect_valid), 32'd0);
    check_eq("arst_pc", redirect_pc, 32'd0);
    check_eq("arst_stall", 32'(stall_id), 32'd0);
    check_eq("arst_flags", {29'd0, br_done, illegal_br, misalign_err}, 32'd0);
    check_counters("arst");
    tick();
    rst_n = 1'b1;
    tick();
    do_branch(0, 0, 3'b100, 32'h800, 32'h8, 32'hFFFF_FFFE, 32'd3, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
